// File: rtl/ieee_decode.sv
// ieee_decode
// Converts an IEEE-754 single-precision operand in the range [1.0, 32.0) to
// a 5-bit integer part plus two truncated decimal fraction digits. Zero (either
// sign) yields all-zero results; negative, non-finite, >= 32.0 or < 1.0 operands
// flag err.
//
// Ports
//   clk       system clock, all state changes on its rising edge
//   rst       synchronous active-high reset
//   start     request to convert in_float, sampled only while busy=0
//   in_float  {sign, exp[7:0], mant[22:0]}
//   busy      high in every state except IDLE
//   done      one-cycle completion pulse; results valid from this cycle on
//   err       operand out of supported range
//   int_part  truncated integer part
//   dig1      tenths digit (0..9)
//   dig2      hundredths digit (0..9)
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | aligning 5.23 fixed-point value, k shifts remaining
// DIG1  | extracting tenths digit
// DIG2  | extracting hundredths digit, publishing results
// FIN   | publishing zero / error result
module ieee_decode (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] in_float,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [4:0]  int_part,
   output logic [3:0]  dig1,
   output logic [3:0]  dig2
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      DIG1  = 3'd2,
      DIG2  = 3'd3,
      FIN   = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [27:0] r, r_nxt;
   logic [2:0]  k, k_nxt;
   logic        cls_err, cls_err_nxt;
   logic [3:0]  d1_q, d1_q_nxt;
   logic        done_nxt, err_nxt;
   logic [4:0]  int_part_nxt;
   logic [3:0]  dig1_nxt, dig2_nxt;

   logic        sgn;
   logic [7:0]  ex;
   logic [22:0] mt;
   logic        is_zero, is_err;
   logic [26:0] prod;

   assign sgn = in_float[31];
   assign ex  = in_float[30:23];
   assign mt  = in_float[22:0];

   assign is_zero = (ex == 8'd0) && (mt == 23'd0);
   assign is_err  = !is_zero &&
                    (sgn || (ex == 8'd255) || (ex > 8'd131) || (ex < 8'd127));

   // Fraction times ten without a multiplier; the top 4 bits are the next digit.
   assign prod = {1'b0, r[22:0], 3'b000} + {3'b000, r[22:0], 1'b0};

   assign busy = (state != IDLE);

   always_comb begin
      state_nxt    = state;
      r_nxt        = r;
      k_nxt        = k;
      cls_err_nxt  = cls_err;
      d1_q_nxt     = d1_q;
      done_nxt     = 1'b0;
      err_nxt      = err;
      int_part_nxt = int_part;
      dig1_nxt     = dig1;
      dig2_nxt     = dig2;

      case (state)
         IDLE: begin
            if (start) begin
               cls_err_nxt = is_err;
               if (is_zero || is_err) begin
                  state_nxt = FIN;
               end else begin
                  r_nxt     = {4'b0000, 1'b1, mt};
                  // exp-127 for exp in 127..131, taken modulo 8
                  k_nxt     = ex[2:0] + 3'd1;
                  state_nxt = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (k != 3'd0) begin
               r_nxt = {r[26:0], 1'b0};
               k_nxt = k - 3'd1;
            end else begin
               state_nxt = DIG1;
            end
         end
         DIG1: begin
            d1_q_nxt  = prod[26:23];
            r_nxt     = {r[27:23], prod[22:0]};
            state_nxt = DIG2;
         end
         DIG2: begin
            r_nxt        = {r[27:23], prod[22:0]};
            int_part_nxt = r[27:23];
            dig1_nxt     = d1_q;
            dig2_nxt     = prod[26:23];
            err_nxt      = 1'b0;
            done_nxt     = 1'b1;
            state_nxt    = IDLE;
         end
         FIN: begin
            int_part_nxt = 5'd0;
            dig1_nxt     = 4'd0;
            dig2_nxt     = 4'd0;
            err_nxt      = cls_err;
            done_nxt     = 1'b1;
            state_nxt    = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         r        <= 28'd0;
         k        <= 3'd0;
         cls_err  <= 1'b0;
         d1_q     <= 4'd0;
         done     <= 1'b0;
         err      <= 1'b0;
         int_part <= 5'd0;
         dig1     <= 4'd0;
         dig2     <= 4'd0;
      end else begin
         state    <= state_nxt;
         r        <= r_nxt;
         k        <= k_nxt;
         cls_err  <= cls_err_nxt;
         d1_q     <= d1_q_nxt;
         done     <= done_nxt;
         err      <= err_nxt;
         int_part <= int_part_nxt;
         dig1     <= dig1_nxt;
         dig2     <= dig2_nxt;
      end
   end

endmodule

// File: tb/tb_ieee_decode.sv
module tb_ieee_decode;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] in_float;
   logic        busy, done, err;
   logic [4:0]  int_part;
   logic [3:0]  dig1, dig2;

   ieee_decode dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_float (in_float),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .int_part (int_part),
      .dig1     (dig1),
      .dig2     (dig2)
   );

   typedef struct {
      logic [4:0] ip;
      logic [3:0] d1;
      logic [3:0] d2;
      logic       e;
      int         due;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: every done pulse must match the oldest expected result
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (!rst && done) begin
            tests++;
            if (q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
               x = q.pop_front();
               if (int_part !== x.ip || dig1 !== x.d1 || dig2 !== x.d2 ||
                   err !== x.e || cyc != x.due) begin
                  fails++;
                  $display("FAIL result: got ip=%0d d1=%0d d2=%0d err=%0b cyc=%0d, required ip=%0d d1=%0d d2=%0d err=%0b cyc=%0d",
                           int_part, dig1, dig2, err, cyc, x.ip, x.d1, x.d2, x.e, x.due);
               end
            end
         end
      end
   end

   // wait (bounded) until done is seen at a negedge
   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL timeout_%s: no done within 30 cycles, required done", name);
         if (q.size() != 0) void'(q.pop_front());
      end
   endtask

   // called at a negedge; issues a one-cycle start and waits for completion
   task automatic run(input string name, input logic [31:0] v, input logic [4:0] ip,
                      input logic [3:0] d1, input logic [3:0] d2, input logic e,
                      input int lat);
      start    = 1'b1;
      in_float = v;
      q.push_back('{ip, d1, d2, e, cyc + 1 + lat});
      @(negedge clk);
      start = 1'b0;
      wait_done(name);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   initial begin
      int c;
      rst      = 1'b1;
      start    = 1'b0;
      in_float = 32'h0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_outs", {18'd0, err, int_part, dig1, dig2}, 32'd0);

      // first edge with rst=0 accepts start
      rst = 1'b0;
      run("one",     32'h3F800000, 5'd1,  4'd0, 4'd0, 1'b0, 3);
      run("five5",   32'h40B00000, 5'd5,  4'd5, 4'd0, 1'b0, 5);
      run("pi",      32'h40490FDB, 5'd3,  4'd1, 4'd4, 1'b0, 4);
      run("max",     32'h41FFFFFF, 5'd31, 4'd9, 4'd9, 1'b0, 7);
      run("half",    32'h3F000000, 5'd0,  4'd0, 4'd0, 1'b1, 1);
      run("n32",     32'h42000000, 5'd0,  4'd0, 4'd0, 1'b1, 1);
      run("neg1",    32'hBF800000, 5'd0,  4'd0, 4'd0, 1'b1, 1);
      run("inf",     32'h7F800000, 5'd0,  4'd0, 4'd0, 1'b1, 1);
      run("negzero", 32'h80000000, 5'd0,  4'd0, 4'd0, 1'b0, 1);
      run("two",     32'h40000000, 5'd2,  4'd0, 4'd0, 1'b0, 4);
      run("ten25",   32'h41240000, 5'd10, 4'd2, 4'd5, 1'b0, 6);

      // hold previous results while idle
      repeat (2) @(negedge clk);
      chk("hold_outs", {18'd0, err, int_part, dig1, dig2}, {18'd0, 1'b0, 5'd10, 4'd2, 4'd5});

      // start pulses while busy are ignored
      start    = 1'b1;
      in_float = 32'h40B00000;
      q.push_back('{5'd5, 4'd5, 4'd0, 1'b0, cyc + 1 + 5});
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("busy_mid", {31'd0, busy}, 32'd1);
      start    = 1'b1;
      in_float = 32'h42000000;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignore");
      repeat (10) @(negedge clk);

      // start held high: one conversion per IDLE cycle
      c        = cyc;
      start    = 1'b1;
      in_float = 32'h3F800000;
      q.push_back('{5'd1, 4'd0, 4'd0, 1'b0, c + 4});
      q.push_back('{5'd1, 4'd0, 4'd0, 1'b0, c + 8});
      for (int i = 0; i < 20 && cyc < c + 5; i++) @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 && cyc < c + 12; i++) @(negedge clk);
      chk("held_queue", q.size(), 32'd0);

      // reset at edge N+2 of a 5.5 conversion aborts it
      c        = cyc;
      start    = 1'b1;
      in_float = 32'h40B00000;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_outs", {18'd0, err, int_part, dig1, dig2}, 32'd0);
      repeat (10) @(negedge clk);
      run("after_abort", 32'h40490FDB, 5'd3, 4'd1, 4'd4, 1'b0, 4);

      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

endmodule

// File: doc/ieee_decode.md
IEEE_DECODE -- requirements
Module: ieee_decode

Interface
REQ-001 The module SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to convert in_float; sampled only while busy=0.
REQ-005 in_float  input  32  IEEE-754 single-precision operand {sign, exp[7:0], mant[22:0]}.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse; results valid from this cycle on.
REQ-008 err  output  1  operand out of supported range.
REQ-009 int_part  output  5  integer part of the operand, truncated.
REQ-010 dig1  output  4  tenths decimal digit, 0..9, truncated.
REQ-011 dig2  output  4  hundredths decimal digit, 0..9, truncated.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT, DIG1, DIG2 and FIN.
REQ-013 In IDLE with start=1 (edge N), the block SHALL capture in_float and classify it.
- zero: exp=0 and mant=0, either sign.
- err: not zero and any of: sign=1; exp=255; exp>131; exp<127.
- valid otherwise.
REQ-014 Zero or err SHALL go to FIN; valid SHALL go to SHIFT with k=exp-127 (0..4).
- Working register R (28 bits) SHALL load {4'b0, 1'b1, mant}, i.e. 5.23 fixed point.
REQ-015 In SHIFT, each edge with k!=0 SHALL shift R left by 1 and decrement k.
- The edge with k=0 SHALL move to DIG1 without shifting.
REQ-016 DIG1 SHALL form P = R[22:0]*10 (27 bits, computed as (F<<3)+(F<<1)).
- It SHALL latch the digit P[26:23], set R[22:0] <= P[22:0], and go to DIG2.
REQ-017 DIG2 SHALL repeat the DIG1 operation for the second digit, then go to IDLE.
- On that edge it SHALL update int_part=R[27:23], dig1, dig2 and err=0, and set done=1.
REQ-018 FIN SHALL go to IDLE, updating the outputs to int_part=0, dig1=0, dig2=0, err=(class==err), and setting done=1.
REQ-019 Latency from the start edge N SHALL be:
- valid operand: done high in the cycle after edge N+k+3.
- zero or err operand: done high in the cycle after edge N+1.
REQ-020 done SHALL be high for exactly one cycle per accepted start.
REQ-021 int_part, dig1, dig2 and err SHALL change only on the edge that raises done, and SHALL hold until the next completion.
REQ-022 start while busy=1 SHALL be ignored, with no queuing.
- start in the same cycle that done is high is accepted, since busy=0 then.
REQ-023 There SHALL be no rounding: all fraction bits below the hundredths digit are truncated.
- The shift cannot overflow R, because exp<=131.
REQ-024 A start held high continuously SHALL start a new conversion on each IDLE cycle.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE and clear R, k, busy, done, err, int_part, dig1 and dig2 to 0.
- rst overrides start.
REQ-026 rst asserted mid-conversion SHALL abort it, with no done pulse for the aborted operation.
REQ-027 The first start SHALL be accepted on the first edge with rst=0.

Verification
REQ-028 0x3F800000 (1.0), start at edge N -> done in the cycle after N+3; int_part=1, dig1=0, dig2=0, err=0.
REQ-029 0x40B00000 (5.5) -> done after N+5; int_part=5, dig1=5, dig2=0, err=0.
- 0x40490FDB (pi) -> done after N+4; int_part=3, dig1=1, dig2=4.
REQ-030 0x41FFFFFF (31.999998) -> done after N+7; int_part=31, dig1=9, dig2=9, err=0.
REQ-031 Each of 0x3F000000 (0.5), 0x42000000 (32.0), 0xBF800000 (-1.0) and 0x7F800000 (+inf) -> done after N+1; err=1, other outputs 0.
- 0x80000000 (-0) -> done after N+1; err=0, all outputs 0.
REQ-032 Handshake and reset:
- start pulses while busy=1 produce no extra done pulses.
- rst at edge N+2 of a 5.5 conversion -> busy=0, no done, outputs 0.
- The next start completes normally.
